bus_arbiter4: RTL and testbench
===============================

Name: bus_arbiter4

Overview:
- Round-robin arbiter that shares one 8-bit datapath resource between four requesters.
- The resource is the 4-input bus mux feeding the ALU/memory bus.
- Grants ownership to one requester at a time and drives the mux select with the owner's index.
- Enforces a bounded hold time so no requester can starve the others.

Parameters:
- MAX_HOLD, 15: max consecutive grant cycles while others are waiting; 0 = unlimited.
- CNT_BITS, 4: width of the hold counter; must satisfy 2^CNT_BITS > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit i = requester i wants the bus; level-sensitive.
- grant  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered owner index; connects to the mux sel input.
- busy  output  1  registered; high while any grant is active.
- timeout  output  1  registered one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async, rst=1):
  - grant=4'b0000, sel=2'b00, busy=0, timeout=0, state=IDLE, cnt=0.
  - Last-owner pointer=3, so requester 0 has highest priority first.
  - Reset mid-grant clears the grant immediately, without waiting for a clock edge.
- States: IDLE, OWNED.
- IDLE:
  - If req!=0, pick the first set bit searching last+1, last+2, last+3, last (mod 4).
  - Next edge: grant=onehot(idx), sel=idx, busy=1, last=idx, cnt=0, go to OWNED.
  - Latency from req to grant is 1 clock.
  - If req==0, stay in IDLE; sel holds its previous value so the mux output stays stable.
- OWNED (owner o):
  - If req[o]==0 at an edge: grant=0, busy=0, go to IDLE. This is a normal release with no timeout pulse.
  - Otherwise cnt increments and saturates at MAX_HOLD.
  - Revoke when MAX_HOLD!=0, cnt==MAX_HOLD-1, req[o]==1 and another req bit is set:
    - grant=0, busy=0, timeout=1 for one cycle, go to IDLE.
    - last=o, so the revoked owner has lowest priority at the next arbitration.
  - If no other requester is pending, the owner keeps the bus indefinitely; cnt saturates.
- Transfers: there is always at least one idle (dead) cycle between grants. This is the bus turnaround cycle, and grants never switch owner directly.
- Simultaneous release and timeout condition: treated as a release (timeout=0).
- Requests asserted while another requester owns the bus are only evaluated in IDLE.
- Requests are not latched: a request dropped before arbitration is lost.
- grant is always one-hot or zero.
- sel always equals the index of the set grant bit whenever busy=1.
- Arithmetic: the pointer and search index wrap modulo 4 using 2-bit arithmetic; cnt is unsigned and never overflows.

Decomposition:
- Shared constants header (arb_defs.vh):
  - ARB_N=4.
  - State codes ST_IDLE=1'b0, ST_OWNED=1'b1.
  - Default MAX_HOLD.
- Sub-module rr_pick4: purely combinational.
  - Inputs req[3:0], last[1:0]; outputs any, idx[1:0].
  - Holds the rotating priority search so it can be verified exhaustively in isolation (all 64 input combinations).
- bus_arbiter4 contains the state register, hold counter and output registers.

Test Plan:
- Reset priority:
  - After rst, req=4'b1111 held -> at the first edge grant=0001, sel=0, busy=1.
  - Drop req[0] -> one idle cycle, then grant=0010, sel=1.
- Round-robin fairness:
  - All four request continuously; each releases after 3 cycles.
  - Grant order is 0,1,2,3,0, with exactly one busy=0 cycle between grants.
- Hold limit (MAX_HOLD=15):
  - req[2] held, req[1] asserted at cycle 2 of the grant.
  - After 15 grant cycles: grant=0, timeout=1 for exactly 1 cycle, next grant=0010.
  - Requester 2 is granted only after requester 1 releases.
- Sole requester:
  - Only req[3] held for 40 cycles -> grant=1000 throughout, timeout never pulses, cnt saturates.
- Async reset mid-grant:
  - rst asserted between edges while grant=0100 -> grant, busy, sel go to 0 immediately.
  - After rst deasserts with req=0100 -> grant=0100 one edge later.
- Release/timeout collision:
  - req[o] drops on the same edge that cnt reaches MAX_HOLD-1 with another request pending -> timeout stays 0, normal release.

Source files
------------

// File: rtl/bus_arbiter4_pkg.sv
// Shared constants for the 4-way round-robin bus arbiter.
package bus_arbiter4_pkg;

  localparam int ARB_N            = 4;
  localparam int DEFAULT_MAX_HOLD = 15;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  function automatic logic [ARB_N-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Rotating-priority search: first set request after 'last', wrapping mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    any   = |req;
    idx   = last;
    cand  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + k[1:0];
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin owner of the 4-input bus mux; one-cycle req->grant, dead cycle
// between owners, and a hold limit that revokes a grant when others wait.
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam logic [CNT_BITS-1:0] HOLD_MAX  = CNT_BITS'(MAX_HOLD);
  localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  logic [0:0]          state_q, state_d;
  logic [3:0]          grant_q, grant_d;
  logic [1:0]          sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [1:0]          last_q, last_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic       pick_any;
  logic [1:0] pick_idx;
  logic       others_pending;
  logic       hold_expired;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign others_pending = |(req & ~grant_q);
  // The counter saturates at MAX_HOLD, so >= keeps a late arrival from being
  // starved by an owner that has already run past the limit alone.
  assign hold_expired   = (MAX_HOLD != 0) && (cnt_q >= HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_OWNED;
          grant_d = onehot4(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_OWNED: begin
        if (!req[sel_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (hold_expired && others_pending) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          last_d    = sel_q;
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4 plus an exhaustive sweep of rr_pick4.
module tb_bus_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  logic [3:0] p_req;
  logic [1:0] p_last;
  logic       p_any;
  logic [1:0] p_idx;

  int total = 0;
  int bad   = 0;

  bus_arbiter4 #(.MAX_HOLD(15), .CNT_BITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  rr_pick4 u_pick_ref (
    .req  (p_req),
    .last (p_last),
    .any  (p_any),
    .idx  (p_idx)
  );

  always #5 clk = ~clk;

  // {grant, sel, busy, timeout}
  function automatic logic [7:0] outv(input logic [3:0] g, input logic [1:0] s,
                                      input logic b, input logic t);
    return {g, s, b, t};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] exp_idx;
    logic [1:0] o;
    logic       hit;

    rst = 1'b1;
    req = 4'b0000;
    p_req = 4'b0000;
    p_last = 2'd0;
    #2;
    chk("reset_state", outv(grant, sel, busy, timeout), 8'h00);
    tick();
    rst = 1'b0;

    // Exhaustive picker sweep using a rotate-then-lowest-bit reference.
    for (int l = 0; l < 4; l++) begin
      for (int r = 0; r < 16; r++) begin
        p_req  = r[3:0];
        p_last = l[1:0];
        #1;
        dbl = {p_req, p_req};
        rot = 4'(dbl >> ({1'b0, p_last} + 3'd1));
        exp_idx = 2'd0;
        hit = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (!hit && rot[j]) begin
            exp_idx = p_last + 2'd1 + j[1:0];
            hit = 1'b1;
          end
        end
        chk("pick_any", {7'd0, p_any}, {7'd0, (r != 0)});
        if (r != 0) chk("pick_idx", {6'd0, p_idx}, {6'd0, exp_idx});
      end
    end

    // Reset priority: requester 0 wins first, then a dead cycle before 1.
    do_reset();
    req = 4'b1111;
    tick();
    chk("rst_prio_g0", outv(grant, sel, busy, timeout), outv(4'b0001, 2'd0, 1'b1, 1'b0));
    req = 4'b1110;
    tick();
    chk("rst_prio_idle", outv(grant, sel, busy, timeout), outv(4'b0000, 2'd0, 1'b0, 1'b0));
    tick();
    chk("rst_prio_g1", outv(grant, sel, busy, timeout), outv(4'b0010, 2'd1, 1'b1, 1'b0));

    // Round robin: each owner holds 3 cycles, order 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      o = i[1:0];
      chk("rr_grant_c1", outv(grant, sel, busy, timeout), outv(4'b0001 << o, o, 1'b1, 1'b0));
      tick();
      chk("rr_grant_c2", outv(grant, sel, busy, timeout), outv(4'b0001 << o, o, 1'b1, 1'b0));
      tick();
      chk("rr_grant_c3", outv(grant, sel, busy, timeout), outv(4'b0001 << o, o, 1'b1, 1'b0));
      req = 4'b1111 & ~(4'b0001 << o);
      tick();
      chk("rr_dead_cycle", outv(grant, sel, busy, timeout), outv(4'b0000, o, 1'b0, 1'b0));
      req = 4'b1111;
      if (i < 4) tick();
    end

    // Hold limit: owner 2 revoked after 15 grant cycles while 1 waits.
    do_reset();
    req = 4'b0100;
    tick();
    chk("hold_c1", outv(grant, sel, busy, timeout), outv(4'b0100, 2'd2, 1'b1, 1'b0));
    tick();
    req = 4'b0110;
    for (int c = 3; c <= 15; c++) begin
      tick();
      chk("hold_owned", outv(grant, sel, busy, timeout), outv(4'b0100, 2'd2, 1'b1, 1'b0));
    end
    tick();
    chk("hold_revoke", outv(grant, sel, busy, timeout), outv(4'b0000, 2'd2, 1'b0, 1'b1));
    tick();
    chk("hold_next_g1", outv(grant, sel, busy, timeout), outv(4'b0010, 2'd1, 1'b1, 1'b0));
    req = 4'b0100;
    tick();
    chk("hold_g1_release", outv(grant, sel, busy, timeout), outv(4'b0000, 2'd1, 1'b0, 1'b0));
    tick();
    chk("hold_back_to_g2", outv(grant, sel, busy, timeout), outv(4'b0100, 2'd2, 1'b1, 1'b0));

    // Sole requester keeps the bus indefinitely with the counter saturated.
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("sole_owner", outv(grant, sel, busy, timeout), outv(4'b1000, 2'd3, 1'b1, 1'b0));
    end
    chk("sole_cnt_sat", {4'd0, dut.cnt_q}, 8'd15);

    // Asynchronous reset between edges clears outputs at once.
    do_reset();
    req = 4'b0100;
    tick();
    chk("arst_pre", outv(grant, sel, busy, timeout), outv(4'b0100, 2'd2, 1'b1, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_immediate", outv(grant, sel, busy, timeout), 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_regrant", outv(grant, sel, busy, timeout), outv(4'b0100, 2'd2, 1'b1, 1'b0));

    // Release on the same edge the hold limit would fire: no timeout.
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0110;
    for (int c = 2; c <= 15; c++) tick();
    chk("coll_c15", outv(grant, sel, busy, timeout), outv(4'b0100, 2'd2, 1'b1, 1'b0));
    req = 4'b0010;
    tick();
    chk("coll_release", outv(grant, sel, busy, timeout), outv(4'b0000, 2'd2, 1'b0, 1'b0));
    tick();
    chk("coll_next_g1", outv(grant, sel, busy, timeout), outv(4'b0010, 2'd1, 1'b1, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
